// File: rtl/remote_cmd_seq.sv
// Remote-side command sequencer: sends one latched opcode/payload through RemoteComm,
// waits for the airframe response, retries on timeout and reports one status per request.
module remote_cmd_seq #(
  parameter logic [7:0]  ACK_VAL     = 8'hA5,
  parameter logic [23:0] TMO_CYC     = 24'd1_000_000,
  parameter logic [23:0] CAL_TMO_CYC = 24'd16_000_000,
  parameter int          MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  req_cmd,
  input  logic [15:0] req_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [7:0]  last_resp,
  output logic [1:0]  retries,
  output logic        send_cmd,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy
);

  localparam logic [7:0]  CAL_OP  = 8'h06;
  localparam logic [1:0]  MAX_R   = 2'(MAX_RETRY);
  localparam logic [23:0] TMO_M1  = TMO_CYC - 24'd1;
  localparam logic [23:0] CAL_M1  = CAL_TMO_CYC - 24'd1;
  localparam logic [1:0]  ST_ACK  = 2'b00;
  localparam logic [1:0]  ST_NAK  = 2'b01;
  localparam logic [1:0]  ST_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_FINISH
  } state_t;

  state_t      r_state, w_state;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [1:0]  r_status, w_status;
  logic [7:0]  r_last_resp, w_last_resp;
  logic [1:0]  r_retries, w_retries;
  logic        r_send_cmd, w_send_cmd;
  logic [7:0]  r_cmd, w_cmd;
  logic [15:0] r_data, w_data;
  logic        r_clr_resp_rdy, w_clr_resp_rdy;
  logic [23:0] r_timer, w_timer;
  logic [23:0] w_limit_m1;

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (&v) ? v : v + 24'd1;
  endfunction

  assign w_limit_m1 = (r_cmd == CAL_OP) ? CAL_M1 : TMO_M1;

  always_comb begin
    w_state        = r_state;
    w_busy         = r_busy;
    w_done         = 1'b0;
    w_status       = r_status;
    w_last_resp    = r_last_resp;
    w_retries      = r_retries;
    w_send_cmd     = 1'b0;
    w_cmd          = r_cmd;
    w_data         = r_data;
    w_clr_resp_rdy = 1'b0;
    w_timer        = r_timer;
    unique case (r_state)
      S_IDLE: begin
        // busy is held through the done cycle and dropped on the first idle edge
        if (r_done) w_busy = 1'b0;
        // Stray bytes are acknowledged once and discarded
        if (resp_rdy && !r_clr_resp_rdy) w_clr_resp_rdy = 1'b1;
        if (req) begin
          w_cmd      = req_cmd;
          w_data     = req_data;
          w_retries  = 2'd0;
          w_timer    = 24'd0;
          w_busy     = 1'b1;
          w_send_cmd = 1'b1;
          w_state    = S_SEND;
        end
      end
      S_SEND: w_state = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (cmd_sent) begin
          w_timer = 24'd0;
          w_state = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        w_timer = sat_inc(r_timer);
        if (resp_rdy) begin
          w_last_resp    = resp;
          w_clr_resp_rdy = 1'b1;
          w_status       = (resp == ACK_VAL) ? ST_ACK : ST_NAK;
          w_state        = S_FINISH;
        end else if (r_timer == w_limit_m1) begin
          if (r_retries < MAX_R) begin
            w_retries  = r_retries + 2'd1;
            w_send_cmd = 1'b1;
            w_state    = S_SEND;
          end else begin
            w_status = ST_TMO;
            w_state  = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_status       <= 2'b00;
      r_last_resp    <= 8'h00;
      r_retries      <= 2'd0;
      r_send_cmd     <= 1'b0;
      r_cmd          <= 8'h00;
      r_data         <= 16'h0000;
      r_clr_resp_rdy <= 1'b0;
      r_timer        <= 24'd0;
    end else begin
      r_state        <= w_state;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_status       <= w_status;
      r_last_resp    <= w_last_resp;
      r_retries      <= w_retries;
      r_send_cmd     <= w_send_cmd;
      r_cmd          <= w_cmd;
      r_data         <= w_data;
      r_clr_resp_rdy <= w_clr_resp_rdy;
      r_timer        <= w_timer;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign status       = r_status;
  assign last_resp    = r_last_resp;
  assign retries      = r_retries;
  assign send_cmd     = r_send_cmd;
  assign cmd          = r_cmd;
  assign data         = r_data;
  assign clr_resp_rdy = r_clr_resp_rdy;

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Directed bench for remote_cmd_seq: table of whole transactions plus hand-written
// sequences for contention, idle stray responses, timeout spacing and reset abort.
module tb_remote_cmd_seq;

  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  req_cmd = 8'h00;
  logic [15:0] req_data = 16'h0000;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        busy, done, send_cmd, clr_resp_rdy;
  logic [1:0]  status, retries;
  logic [7:0]  last_resp, cmd;
  logic [15:0] data;

  int n_vec  = 0;
  int n_miss = 0;
  int mon_send = 0, mon_clr = 0, mon_done = 0;

  remote_cmd_seq #(
    .ACK_VAL(8'hA5), .TMO_CYC(24'd100), .CAL_TMO_CYC(24'd5000), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_data(req_data),
    .busy(busy), .done(done), .status(status), .last_resp(last_resp),
    .retries(retries), .send_cmd(send_cmd), .cmd(cmd), .data(data),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy)
  );

  always #5 clk = ~clk;

  // Pulse counters: sampled on the active edge, so each one-cycle pulse counts once
  always @(posedge clk) begin
    if (rst_n) begin
      if (send_cmd)     mon_send++;
      if (clr_resp_rdy) mon_clr++;
      if (done)         mon_done++;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    int          sent_dly;   // cycles from send_cmd to cmd_sent (>= 1)
    int          resp_att;   // attempt index that gets a response (3 = never)
    int          resp_dly;   // cycles from cmd_sent to resp_rdy
    logic [7:0]  resp;
    logic [1:0]  exp_status;
    logic [7:0]  exp_last;
    logic [1:0]  exp_retries;
    int          exp_send;
    int          exp_clr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s0, c0, d0, att, cyc;
    bit hit;
    s0 = mon_send; c0 = mon_clr; d0 = mon_done;
    @(negedge clk); req = 1'b1; req_cmd = v.cmd; req_data = v.data;
    @(negedge clk); req = 1'b0; req_cmd = ~v.cmd; req_data = ~v.data;
    chk($sformatf("%s.accept_busy", tag), busy, 1);
    chk($sformatf("%s.cmd", tag), cmd, v.cmd);
    chk($sformatf("%s.data", tag), data, v.data);
    att = 0; hit = 0;
    while (!hit) begin
      cyc = 0;
      while (!(send_cmd || done) && cyc < BUDGET) begin @(negedge clk); cyc++; end
      if (!(send_cmd || done)) begin
        chk($sformatf("%s.wait_timeout", tag), 0, 1);
        return;
      end
      if (done) hit = 1;
      else begin
        repeat (v.sent_dly) @(negedge clk);
        cmd_sent = 1'b1; @(negedge clk); cmd_sent = 1'b0;
        if (att == v.resp_att) begin
          repeat (v.resp_dly) @(negedge clk);
          resp_rdy = 1'b1; resp = v.resp;
          @(negedge clk); resp_rdy = 1'b0;
        end
        att++;
      end
    end
    chk($sformatf("%s.status", tag), status, v.exp_status);
    chk($sformatf("%s.last_resp", tag), last_resp, v.exp_last);
    chk($sformatf("%s.retries", tag), retries, v.exp_retries);
    chk($sformatf("%s.busy_at_done", tag), busy, 1);
    chk($sformatf("%s.cmd_held", tag), cmd, v.cmd);
    @(negedge clk);
    chk($sformatf("%s.done_low", tag), done, 0);
    chk($sformatf("%s.busy_low", tag), busy, 0);
    chk($sformatf("%s.n_send", tag), mon_send - s0, v.exp_send);
    chk($sformatf("%s.n_clr", tag), mon_clr - c0, v.exp_clr);
    chk($sformatf("%s.n_done", tag), mon_done - d0, 1);
  endtask

  initial begin
    int c, d0;
    //         cmd    data      sdly att rdly resp   st     last   rty  ns nc
    vecs[0] = '{8'h02, 16'hBEEF, 10, 0,  50,  8'hA5, 2'b00, 8'hA5, 2'd0, 1, 1};
    vecs[1] = '{8'h05, 16'h1234, 3,  0,  20,  8'hFF, 2'b01, 8'hFF, 2'd0, 1, 1};
    vecs[2] = '{8'h11, 16'h0000, 2,  3,  0,   8'h00, 2'b10, 8'hFF, 2'd2, 3, 0};
    vecs[3] = '{8'h06, 16'hCA1B, 1,  0,  3999, 8'hA5, 2'b00, 8'hA5, 2'd0, 1, 1};
    vecs[4] = '{8'h06, 16'hCA1C, 1,  1,  10,  8'hA5, 2'b00, 8'hA5, 2'd1, 2, 1};
    vecs[5] = '{8'h07, 16'h5555, 4,  0,  99,  8'hA5, 2'b00, 8'hA5, 2'd0, 1, 1};
    vecs[6] = '{8'h08, 16'h0001, 1,  2,  5,   8'h3C, 2'b01, 8'h3C, 2'd2, 3, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.status", status, 0);
    chk("rst.last_resp", last_resp, 0);
    chk("rst.retries", retries, 0);
    chk("rst.send_cmd", send_cmd, 0);
    chk("rst.cmd", cmd, 0);
    chk("rst.data", data, 0);
    chk("rst.clr", clr_resp_rdy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // req while busy is ignored
    @(negedge clk); req = 1'b1; req_cmd = 8'h02; req_data = 16'hBEEF;
    @(negedge clk); req = 1'b0;
    repeat (3) @(negedge clk);
    req = 1'b1; req_cmd = 8'h33; req_data = 16'h4444;
    @(negedge clk); req = 1'b0;
    chk("busyreq.cmd", cmd, 8'h02);
    chk("busyreq.data", data, 16'hBEEF);
    cmd_sent = 1'b1; @(negedge clk); cmd_sent = 1'b0;
    repeat (10) @(negedge clk);
    resp_rdy = 1'b1; resp = 8'hA5; @(negedge clk); resp_rdy = 1'b0;
    c = 0;
    while (!done && c < 10) begin @(negedge clk); c++; end
    chk("busyreq.done_seen", done, 1);
    chk("busyreq.status", status, 2'b00);
    chk("busyreq.cmd_end", cmd, 8'h02);
    repeat (2) @(negedge clk);

    // Stray response while idle
    resp_rdy = 1'b1; resp = 8'h77;
    @(negedge clk); resp_rdy = 1'b0;
    chk("stray.clr", clr_resp_rdy, 1);
    chk("stray.last_resp", last_resp, 8'hA5);
    chk("stray.busy", busy, 0);
    @(negedge clk);
    chk("stray.clr_low", clr_resp_rdy, 0);

    // Timeout spacing: expiry exactly 100 cycles after cmd_sent
    @(negedge clk); req = 1'b1; req_cmd = 8'h21; req_data = 16'h0F0F;
    @(negedge clk); req = 1'b0;
    for (int a = 0; a < 3; a++) begin
      @(negedge clk); cmd_sent = 1'b1;
      @(negedge clk); cmd_sent = 1'b0;
      c = 0;
      while (!(send_cmd || done) && c < 1000) begin @(negedge clk); c++; end
      chk($sformatf("tmo.spacing%0d", a), c, (a < 2) ? 100 : 101);
      chk($sformatf("tmo.retries%0d", a), retries, (a < 2) ? a + 1 : 2);
    end
    chk("tmo.status", status, 2'b10);
    repeat (2) @(negedge clk);

    // Reset while waiting for a response
    @(negedge clk); req = 1'b1; req_cmd = 8'h09; req_data = 16'hABCD;
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);
    cmd_sent = 1'b1; @(negedge clk); cmd_sent = 1'b0;
    repeat (20) @(negedge clk);
    d0 = mon_done;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.cmd", cmd, 0);
    chk("abort.data", data, 0);
    chk("abort.last_resp", last_resp, 0);
    chk("abort.status", status, 0);
    chk("abort.retries", retries, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort.no_done", mon_done - d0, 0);
    chk("abort.no_send", send_cmd, 0);
    run_vec(vecs[0], "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
